oam_dma_controller: RTL



---
 rtl/oam_dma_controller.sv | 72 +++++++
 1 files changed

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: halts the CPU on a write to REG_ADDR and copies XFER_LEN bytes
// from page {page,8'h00} to the PPU OAM data port, owning the bus while it runs.
module oam_dma_controller #(
    parameter logic [15:0] REG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR = 16'h2004,
    parameter int          XFER_LEN = 256
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  mem_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic        dma_done,
    output logic        cycle_odd
);
    localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
    state_t     state;
    logic [7:0] page, idx, latch;
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state     <= IDLE;
            page      <= '0;
            idx       <= '0;
            latch     <= '0;
            cycle_odd <= 1'b0;
            cpu_rdy   <= 1'b1;
            dma_busy  <= 1'b0;
            dma_done  <= 1'b0;
        end else begin
            cycle_odd <= ~cycle_odd;
            dma_done  <= 1'b0;
            case (state)
                IDLE: if (cpu_we && cpu_addr == REG_ADDR) begin
                    page     <= cpu_dout;
                    idx      <= '0;
                    state    <= HALT;
                    cpu_rdy  <= 1'b0;
                    dma_busy <= 1'b1;
                end
                // reads must land on even cycles; an odd HALT goes straight to READ
                HALT:  state <= cycle_odd ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    latch    <= mem_din;
                    state    <= WRITE;
                    dma_done <= idx == LAST;
                end
                WRITE: if (idx == LAST) begin
                    state    <= IDLE;
                    cpu_rdy  <= 1'b1;
                    dma_busy <= 1'b0;
                end else begin
                    idx   <= idx + 8'd1;
                    state <= READ;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        bus_addr = state == IDLE ? cpu_addr : state == WRITE ? OAM_ADDR : {page, state == READ ? idx : 8'h00};
        bus_dout = state == IDLE ? cpu_dout : state == WRITE ? latch : 8'h00;
        bus_we   = state == IDLE ? cpu_we : state == WRITE;
    end
endmodule
